cam_alloc: RTL and testbench

Self-allocating content-addressable memory with pseudo-LRU replacement, multiple registered lookup ports, key invalidation and full flush. It is the parametrised successor to the two-entry update-by-index CAM. Clients insert by key only; the block picks the slot, reports any eviction and never holds duplicate keys. It is intended for TLBs and miss-tracking tables that need more than one lookup per cycle.

---
 rtl/cam_alloc_pkg.sv | 29 ++
 rtl/cam_alloc_plru.sv | 92 +++++++++
 rtl/cam_alloc.sv | 209 ++++++++++++++++++++
 tb/tb_cam_alloc.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_alloc_pkg.sv
// cam_alloc shared types and helpers.
// Insert classification and one-hot/priority encoding.
package cam_alloc_pkg;

    // Widest vector the encoder helper accepts.
    localparam int OH_MAX = 64;

    typedef enum logic [2:0] {
        INS_NONE,
        INS_FLUSH,
        INS_HIT,
        INS_FREE,
        INS_EVICT
    } ins_kind_e;

    // Index of the lowest set bit, 0 when empty.
    // Doubles as one-hot to index encoder.
    function automatic int lowest_set(
        input logic [OH_MAX-1:0] v
    );
        int r;
        r = 0;
        for (int i = OH_MAX - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/cam_alloc_plru.sv
// Tree pseudo-LRU for cam_alloc.
// Ordered multi-touch update, flush, victim walk.
module cam_plru #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_TOUCH   = 3,
    parameter int IW          = $clog2(NUM_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_flush,
    input  logic [NUM_TOUCH-1:0]          i_touch_en,
    input  logic [NUM_TOUCH-1:0][IW-1:0]  i_touch_idx,
    input  logic                          i_excl_en,
    input  logic [IW-1:0]                 i_excl_idx,
    output logic [IW-1:0]                 o_victim
);

    localparam int NB = NUM_ENTRIES - 1;

    logic [NB-1:0] r_bits;
    logic [NB-1:0] w_bits_nxt;
    logic [NB-1:0] w_bits_excl;
    logic [IW-1:0] w_victim_base;
    logic [IW-1:0] w_victim_excl;

    // Heap-ordered nodes; bit 0 steers the victim left.
    // A touch points every node on its path away from it.
    function automatic logic [NB-1:0] f_touch(
        input logic [NB-1:0] b,
        input logic [IW-1:0] s
    );
        logic [NB-1:0] r;
        int            node;
        r    = b;
        node = 0;
        for (int l = 0; l < IW; l++) begin
            r[node] = ~s[IW-1-l];
            node    = 2 * node + 1 + int'(s[IW-1-l]);
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] f_walk(
        input logic [NB-1:0] b
    );
        logic [IW-1:0] v;
        logic          d;
        int            node;
        v    = '0;
        node = 0;
        for (int l = 0; l < IW; l++) begin
            d          = b[node];
            v[IW-1-l]  = d;
            node       = 2 * node + 1 + int'(d);
        end
        return v;
    endfunction

    // Apply touches in port order; later ones win shared nodes.
    always_comb begin
        w_bits_nxt = r_bits;
        for (int t = 0; t < NUM_TOUCH; t++) begin
            if (i_touch_en[t]) begin
                w_bits_nxt = f_touch(w_bits_nxt, i_touch_idx[t]);
            end
        end
    end

    // Victim skips a slot being freed this cycle by
    // walking as if that slot had just been used.
    always_comb begin
        w_victim_base = f_walk(r_bits);
        w_bits_excl   = f_touch(r_bits, i_excl_idx);
        w_victim_excl = f_walk(w_bits_excl);
        o_victim      = w_victim_base;
        if (i_excl_en && (w_victim_base == i_excl_idx)) begin
            o_victim = w_victim_excl;
        end
    end

    // Tree state register; flush returns it to all-left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bits <= '0;
        end else if (i_flush) begin
            r_bits <= '0;
        end else begin
            r_bits <= w_bits_nxt;
        end
    end

endmodule

// File: rtl/cam_alloc.sv
// Self-allocating CAM with tree-PLRU replacement.
// Multi-port registered lookup, invalidate and flush.
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int NUM_ENTRIES      = 8,
    parameter int KEY_WIDTH        = 32,
    parameter int NUM_LOOKUP_PORTS = 2,
    parameter int INDEX_WIDTH      = $clog2(NUM_ENTRIES)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_LOOKUP_PORTS-1:0]                   lookup_en,
    input  logic [NUM_LOOKUP_PORTS-1:0][KEY_WIDTH-1:0]    lookup_key,
    output logic [NUM_LOOKUP_PORTS-1:0]                   lookup_hit,
    output logic [NUM_LOOKUP_PORTS-1:0][INDEX_WIDTH-1:0]  lookup_idx,
    input  logic                                          insert_en,
    input  logic [KEY_WIDTH-1:0]                          insert_key,
    output logic                                          insert_done,
    output logic [INDEX_WIDTH-1:0]                        insert_idx,
    output logic                                          insert_evict,
    output logic [KEY_WIDTH-1:0]                          evict_key,
    input  logic                                          invalidate_en,
    input  logic [KEY_WIDTH-1:0]                          invalidate_key,
    input  logic                                          flush_en
);

    localparam int P  = NUM_LOOKUP_PORTS;
    localparam int NE = NUM_ENTRIES;
    localparam int IW = INDEX_WIDTH;

    logic [KEY_WIDTH-1:0]    r_key [NE];
    logic [NE-1:0]           r_valid;
    logic [NE-1:0]           w_valid_nxt;

    logic [P-1:0][NE-1:0]    w_lk_match;
    logic [P-1:0][IW-1:0]    w_lk_idx;
    logic [NE-1:0]           w_ins_match;
    logic [NE-1:0]           w_inv_match;
    logic [NE-1:0]           w_free;
    logic [IW-1:0]           w_inv_idx;
    logic                    w_inv_same;
    logic                    w_inv_apply;
    logic [IW-1:0]           w_victim;
    ins_kind_e               w_kind;
    logic [IW-1:0]           w_ins_idx;
    logic                    w_ins_write;

    logic [P:0]              w_touch_en;
    logic [P:0][IW-1:0]      w_touch_idx;

    logic [P-1:0]            r_lk_hit;
    logic [P-1:0][IW-1:0]    r_lk_idx;
    logic                    r_done;
    logic [IW-1:0]           r_ins_idx;
    logic                    r_evict;
    logic [KEY_WIDTH-1:0]    r_evict_key;

    function automatic logic [IW-1:0] f_enc(
        input logic [NE-1:0] v
    );
        logic [OH_MAX-1:0] x;
        x         = '0;
        x[NE-1:0] = v;
        return IW'(lowest_set(x));
    endfunction

    // Per-port match against valid entries, gated by enable.
    always_comb begin
        w_lk_match = '0;
        w_lk_idx   = '0;
        for (int p = 0; p < P; p++) begin
            for (int e = 0; e < NE; e++) begin
                w_lk_match[p][e] = lookup_en[p] && r_valid[e]
                                   && (r_key[e] == lookup_key[p]);
            end
            w_lk_idx[p] = f_enc(w_lk_match[p]);
        end
    end

    // Insert and invalidate match vectors.
    always_comb begin
        w_ins_match = '0;
        w_inv_match = '0;
        for (int e = 0; e < NE; e++) begin
            w_ins_match[e] = r_valid[e] && (r_key[e] == insert_key);
            w_inv_match[e] = r_valid[e] && (r_key[e] == invalidate_key);
        end
    end

    assign w_free      = ~r_valid;
    assign w_inv_idx   = f_enc(w_inv_match);
    assign w_inv_same  = insert_en && (invalidate_key == insert_key);
    assign w_inv_apply = invalidate_en && !w_inv_same && (|w_inv_match);

    // Slot choice: existing key, lowest free, then PLRU victim.
    always_comb begin
        w_kind    = INS_NONE;
        w_ins_idx = '0;
        if (insert_en) begin
            if (flush_en) begin
                w_kind = INS_FLUSH;
            end else if (|w_ins_match) begin
                w_kind    = INS_HIT;
                w_ins_idx = f_enc(w_ins_match);
            end else if (|w_free) begin
                w_kind    = INS_FREE;
                w_ins_idx = f_enc(w_free);
            end else begin
                w_kind    = INS_EVICT;
                w_ins_idx = w_victim;
            end
        end
    end

    assign w_ins_write = (w_kind == INS_HIT) || (w_kind == INS_FREE)
                         || (w_kind == INS_EVICT);

    // Next valid vector: flush wins, then clear, then insert.
    always_comb begin
        w_valid_nxt = r_valid;
        if (flush_en) begin
            w_valid_nxt = '0;
        end else begin
            if (w_inv_apply) w_valid_nxt[w_inv_idx] = 1'b0;
            if (w_ins_write) w_valid_nxt[w_ins_idx] = 1'b1;
        end
    end

    // PLRU touches: lookup ports in order, insert last.
    always_comb begin
        w_touch_en  = '0;
        w_touch_idx = '0;
        for (int p = 0; p < P; p++) begin
            w_touch_en[p]  = (|w_lk_match[p]) && !flush_en;
            w_touch_idx[p] = w_lk_idx[p];
        end
        w_touch_en[P]  = w_ins_write;
        w_touch_idx[P] = w_ins_idx;
    end

    cam_plru #(
        .NUM_ENTRIES (NE),
        .NUM_TOUCH   (P + 1),
        .IW          (IW)
    ) u_plru (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (flush_en),
        .i_touch_en  (w_touch_en),
        .i_touch_idx (w_touch_idx),
        .i_excl_en   (w_inv_apply),
        .i_excl_idx  (w_inv_idx),
        .o_victim    (w_victim)
    );

    // Valid bits are the only reset table state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Key storage is left unreset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (w_ins_write) begin
            r_key[w_ins_idx] <= insert_key;
        end
    end

    // Registered lookup and insert results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lk_hit    <= '0;
            r_lk_idx    <= '0;
            r_done      <= 1'b0;
            r_ins_idx   <= '0;
            r_evict     <= 1'b0;
            r_evict_key <= '0;
        end else begin
            for (int p = 0; p < P; p++) begin
                r_lk_hit[p] <= |w_lk_match[p];
                r_lk_idx[p] <= w_lk_idx[p];
            end
            r_done      <= insert_en;
            r_ins_idx   <= w_ins_idx;
            r_evict     <= (w_kind == INS_EVICT);
            r_evict_key <= (w_kind == INS_EVICT) ? r_key[w_ins_idx] : '0;
        end
    end

    assign lookup_hit   = r_lk_hit;
    assign lookup_idx   = r_lk_idx;
    assign insert_done  = r_done;
    assign insert_idx   = r_ins_idx;
    assign insert_evict = r_evict;
    assign evict_key    = r_evict_key;

    // Duplicate keys would make a lookup match twice.
    for (genvar gp = 0; gp < P; gp++) begin : g_onehot
        a_lk_onehot: assert property (
            @(posedge clk) disable iff (reset)
            $onehot0(w_lk_match[gp])
        );
    end

endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc.
// Directed scenarios plus randomized traffic against a model.
module tb_cam_alloc;

    localparam int NE = 8;
    localparam int KW = 32;
    localparam int P  = 2;
    localparam int IW = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [P-1:0]            lookup_en;
    logic [P-1:0][KW-1:0]    lookup_key;
    logic [P-1:0]            lookup_hit;
    logic [P-1:0][IW-1:0]    lookup_idx;
    logic                    insert_en;
    logic [KW-1:0]           insert_key;
    logic                    insert_done;
    logic [IW-1:0]           insert_idx;
    logic                    insert_evict;
    logic [KW-1:0]           evict_key;
    logic                    invalidate_en;
    logic [KW-1:0]           invalidate_key;
    logic                    flush_en;

    always #5 clk = ~clk;

    cam_alloc #(
        .NUM_ENTRIES      (NE),
        .KEY_WIDTH        (KW),
        .NUM_LOOKUP_PORTS (P)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_en      (lookup_en),
        .lookup_key     (lookup_key),
        .lookup_hit     (lookup_hit),
        .lookup_idx     (lookup_idx),
        .insert_en      (insert_en),
        .insert_key     (insert_key),
        .insert_done    (insert_done),
        .insert_idx     (insert_idx),
        .insert_evict   (insert_evict),
        .evict_key      (evict_key),
        .invalidate_en  (invalidate_en),
        .invalidate_key (invalidate_key),
        .flush_en       (flush_en)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: slots hold key/valid plus the time each slot was
    // last used since the last flush (0 = untouched).
    logic [KW-1:0] mkey [NE];
    bit            mvalid [NE];
    int unsigned   mstamp [NE];
    int unsigned   mnow = 0;

    bit            exp_hit [P];
    int            exp_lidx [P];
    bit            exp_done;
    int            exp_iidx;
    bit            exp_ev;
    logic [KW-1:0] exp_evk;

    function automatic void m_reset();
        for (int e = 0; e < NE; e++) begin
            mvalid[e] = 0;
            mstamp[e] = 0;
        end
    endfunction

    function automatic void m_touch(int s);
        mnow++;
        mstamp[s] = mnow;
    endfunction

    // Descend halves, avoiding the half holding the most
    // recent use; untouched halves go left.
    function automatic int m_victim();
        int          lo;
        int          sz;
        int          half;
        int unsigned ml;
        int unsigned mr;
        lo = 0;
        sz = NE;
        while (sz > 1) begin
            half = sz / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (mstamp[lo + i] > ml) ml = mstamp[lo + i];
                if (mstamp[lo + half + i] > mr) mr = mstamp[lo + half + i];
            end
            if (ml > mr) lo = lo + half;
            sz = half;
        end
        return lo;
    endfunction

    // Predict outputs from current inputs, then advance model.
    function automatic void m_eval();
        int          fi;
        int          slot;
        bit          same;
        bit          inv_apply;
        int unsigned sv;
        for (int p = 0; p < P; p++) begin
            exp_hit[p]  = 0;
            exp_lidx[p] = 0;
            if (lookup_en[p]) begin
                for (int e = 0; e < NE; e++) begin
                    if (mvalid[e] && mkey[e] == lookup_key[p]) begin
                        exp_hit[p]  = 1;
                        exp_lidx[p] = e;
                    end
                end
            end
        end
        exp_done = insert_en;
        exp_iidx = 0;
        exp_ev   = 0;
        exp_evk  = '0;
        if (flush_en) begin
            m_reset();
            return;
        end
        fi = -1;
        for (int e = 0; e < NE; e++) begin
            if (mvalid[e] && mkey[e] == invalidate_key) fi = e;
        end
        same      = insert_en && (invalidate_key == insert_key);
        inv_apply = invalidate_en && !same && (fi >= 0);
        slot = -1;
        if (insert_en) begin
            for (int e = 0; e < NE; e++) begin
                if (mvalid[e] && mkey[e] == insert_key) slot = e;
            end
            if (slot < 0) begin
                for (int e = NE - 1; e >= 0; e--) begin
                    if (!mvalid[e]) slot = e;
                end
            end
            if (slot < 0) begin
                slot = m_victim();
                if (inv_apply && slot == fi) begin
                    sv         = mstamp[fi];
                    mstamp[fi] = mnow + 1;
                    slot       = m_victim();
                    mstamp[fi] = sv;
                end
                exp_ev  = 1;
                exp_evk = mkey[slot];
            end
            exp_iidx = slot;
        end
        for (int p = 0; p < P; p++) begin
            if (exp_hit[p]) m_touch(exp_lidx[p]);
        end
        if (inv_apply) mvalid[fi] = 0;
        if (insert_en) begin
            mkey[slot]   = insert_key;
            mvalid[slot] = 1;
            m_touch(slot);
        end
    endfunction

    task automatic idle();
        lookup_en      = '0;
        lookup_key     = '0;
        insert_en      = 1'b0;
        insert_key     = '0;
        invalidate_en  = 1'b0;
        invalidate_key = '0;
        flush_en       = 1'b0;
    endtask

    task automatic step();
        m_eval();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (lookup_hit !== 2'b00) begin n_fail++; $display("FAIL rst_hit got %b want 00", lookup_hit); end
        n_tests++; if (lookup_idx !== '0) begin n_fail++; $display("FAIL rst_lidx got %h want 0", lookup_idx); end
        n_tests++; if (insert_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", insert_done); end
        n_tests++; if (insert_idx !== '0) begin n_fail++; $display("FAIL rst_iidx got %0d want 0", insert_idx); end
        n_tests++; if (insert_evict !== 1'b0) begin n_fail++; $display("FAIL rst_evict got %b want 0", insert_evict); end
        n_tests++; if (evict_key !== '0) begin n_fail++; $display("FAIL rst_evkey got %h want 0", evict_key); end
        reset = 1'b0;
        m_reset();
        lookup_en  = 2'b11;
        lookup_key = '0;
        step();
        n_tests++; if (lookup_hit !== 2'b00) begin n_fail++; $display("FAIL rst_lookup0 got %b want 00", lookup_hit); end
        n_tests++; if (lookup_idx !== '0) begin n_fail++; $display("FAIL rst_lookup0_idx got %h want 0", lookup_idx); end
    endtask

    task automatic test_basic_insert();
        insert_en = 1'b1; insert_key = 32'h10;
        step();
        n_tests++; if (insert_done !== 1'b1 || insert_idx !== 3'd0) begin n_fail++; $display("FAIL ins10 done=%b idx=%0d want 1/0", insert_done, insert_idx); end
        n_tests++; if (insert_evict !== 1'b0) begin n_fail++; $display("FAIL ins10_evict got %b want 0", insert_evict); end
        insert_en = 1'b1; insert_key = 32'h20;
        step();
        n_tests++; if (insert_done !== 1'b1 || insert_idx !== 3'd1) begin n_fail++; $display("FAIL ins20 done=%b idx=%0d want 1/1", insert_done, insert_idx); end
        n_tests++; if (insert_evict !== 1'b0) begin n_fail++; $display("FAIL ins20_evict got %b want 0", insert_evict); end
        lookup_en = 2'b10; lookup_key[1] = 32'h20;
        step();
        n_tests++; if (lookup_hit !== 2'b10 || lookup_idx[1] !== 3'd1) begin n_fail++; $display("FAIL lk20 hit=%b idx=%0d want 10/1", lookup_hit, lookup_idx[1]); end
        n_tests++; if (insert_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", insert_done); end
    endtask

    task automatic test_fill_evict();
        flush_en = 1'b1;
        step();
        for (int i = 0; i < NE; i++) begin
            insert_en = 1'b1; insert_key = 32'h100 + i;
            step();
            n_tests++; if (insert_idx !== IW'(i) || insert_evict !== 1'b0) begin n_fail++; $display("FAIL fill%0d idx=%0d ev=%b want %0d/0", i, insert_idx, insert_evict, i); end
        end
        repeat (3) begin
            for (int i = 0; i < 4; i++) begin
                lookup_en = 2'b01; lookup_key[0] = 32'h100 + i;
                step();
                n_tests++; if (lookup_hit[0] !== 1'b1 || lookup_idx[0] !== IW'(i)) begin n_fail++; $display("FAIL hot%0d hit=%b idx=%0d want 1/%0d", i, lookup_hit[0], lookup_idx[0], i); end
            end
        end
        insert_en = 1'b1; insert_key = 32'h200;
        step();
        n_tests++; if (insert_evict !== 1'b1) begin n_fail++; $display("FAIL ev200 evict got %b want 1", insert_evict); end
        n_tests++; if (evict_key < 32'h104 || evict_key > 32'h107) begin n_fail++; $display("FAIL ev200_range got %h want 104..107", evict_key); end
        n_tests++; if (evict_key !== exp_evk || insert_idx !== IW'(exp_iidx)) begin n_fail++; $display("FAIL ev200_plru got %h/%0d want %h/%0d", evict_key, insert_idx, exp_evk, exp_iidx); end
    endtask

    task automatic test_reinsert();
        insert_en = 1'b1; insert_key = 32'h105;
        step();
        n_tests++; if (insert_idx !== 3'd5 || insert_evict !== 1'b0) begin n_fail++; $display("FAIL re105 idx=%0d ev=%b want 5/0", insert_idx, insert_evict); end
        lookup_en = 2'b11; lookup_key[0] = 32'h105; lookup_key[1] = 32'h105;
        step();
        n_tests++; if (lookup_hit !== 2'b11 || lookup_idx[0] !== 3'd5 || lookup_idx[1] !== 3'd5) begin n_fail++; $display("FAIL lk105 hit=%b idx=%0d/%0d want 11/5/5", lookup_hit, lookup_idx[0], lookup_idx[1]); end
    endtask

    task automatic test_inv_insert();
        lookup_en = 2'b11; lookup_key[0] = 32'h100; lookup_key[1] = 32'h102;
        step();
        lookup_en = 2'b01; lookup_key[0] = 32'h105;
        step();
        invalidate_en = 1'b1; invalidate_key = 32'h101;
        insert_en = 1'b1; insert_key = 32'h300;
        step();
        n_tests++; if (insert_idx === 3'd1) begin n_fail++; $display("FAIL inv_slot got %0d want not 1", insert_idx); end
        n_tests++; if (insert_idx !== IW'(exp_iidx) || insert_evict !== exp_ev || evict_key !== exp_evk) begin n_fail++; $display("FAIL ins300 got %0d/%b/%h want %0d/%b/%h", insert_idx, insert_evict, evict_key, exp_iidx, exp_ev, exp_evk); end
        lookup_en = 2'b11; lookup_key[0] = 32'h101; lookup_key[1] = 32'h300;
        step();
        n_tests++; if (lookup_hit !== 2'b10 || lookup_idx[1] !== IW'(exp_lidx[1])) begin n_fail++; $display("FAIL lk101_300 hit=%b idx=%0d want 10/%0d", lookup_hit, lookup_idx[1], exp_lidx[1]); end
        invalidate_en = 1'b1; invalidate_key = 32'h102;
        insert_en = 1'b1; insert_key = 32'h102;
        step();
        n_tests++; if (insert_idx !== 3'd2 || insert_evict !== 1'b0) begin n_fail++; $display("FAIL same102 idx=%0d ev=%b want 2/0", insert_idx, insert_evict); end
        lookup_en = 2'b01; lookup_key[0] = 32'h102;
        step();
        n_tests++; if (lookup_hit[0] !== 1'b1 || lookup_idx[0] !== 3'd2) begin n_fail++; $display("FAIL lk102 hit=%b idx=%0d want 1/2", lookup_hit[0], lookup_idx[0]); end
    endtask

    task automatic test_flush();
        flush_en = 1'b1; insert_en = 1'b1; insert_key = 32'h400;
        step();
        n_tests++; if (insert_done !== 1'b1 || insert_idx !== 3'd0 || insert_evict !== 1'b0) begin n_fail++; $display("FAIL flush_ins got %b/%0d/%b want 1/0/0", insert_done, insert_idx, insert_evict); end
        lookup_en = 2'b11; lookup_key[0] = 32'h400; lookup_key[1] = 32'h102;
        step();
        n_tests++; if (lookup_hit !== 2'b00) begin n_fail++; $display("FAIL flush_lk got %b want 00", lookup_hit); end
        insert_en = 1'b1; insert_key = 32'h410;
        step();
        n_tests++; if (insert_idx !== 3'd0 || insert_evict !== 1'b0) begin n_fail++; $display("FAIL post_flush idx=%0d ev=%b want 0/0", insert_idx, insert_evict); end
    endtask

    task automatic test_reset_mid();
        insert_en = 1'b1; insert_key = 32'h500;
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (insert_done !== 1'b0) begin n_fail++; $display("FAIL rst_async_done got %b want 0", insert_done); end
        @(posedge clk);
        #1;
        n_tests++; if (insert_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", insert_done); end
        idle();
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        n_tests++; if (insert_done !== 1'b0) begin n_fail++; $display("FAIL rst_after_done got %b want 0", insert_done); end
        insert_en = 1'b1; insert_key = 32'h500;
        step();
        n_tests++; if (insert_idx !== 3'd0 || insert_evict !== 1'b0) begin n_fail++; $display("FAIL rst_ins idx=%0d ev=%b want 0/0", insert_idx, insert_evict); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            lookup_en      = P'($urandom_range(0, 3));
            lookup_key[0]  = 32'h600 + $urandom_range(0, 11);
            lookup_key[1]  = 32'h600 + $urandom_range(0, 11);
            insert_en      = ($urandom_range(0, 1) == 1);
            insert_key     = 32'h600 + $urandom_range(0, 11);
            invalidate_en  = ($urandom_range(0, 3) == 0);
            invalidate_key = 32'h600 + $urandom_range(0, 11);
            flush_en       = ($urandom_range(0, 39) == 0);
            step();
            for (int p = 0; p < P; p++) begin
                n_tests++; if (lookup_hit[p] !== exp_hit[p] || lookup_idx[p] !== IW'(exp_lidx[p])) begin n_fail++; $display("FAIL rnd%0d_lk%0d got %b/%0d want %b/%0d", c, p, lookup_hit[p], lookup_idx[p], exp_hit[p], exp_lidx[p]); end
            end
            n_tests++; if (insert_done !== exp_done) begin n_fail++; $display("FAIL rnd%0d_done got %b want %b", c, insert_done, exp_done); end
            if (exp_done) begin
                n_tests++; if (insert_idx !== IW'(exp_iidx) || insert_evict !== exp_ev) begin n_fail++; $display("FAIL rnd%0d_ins got %0d/%b want %0d/%b", c, insert_idx, insert_evict, exp_iidx, exp_ev); end
            end
            if (exp_ev) begin
                n_tests++; if (evict_key !== exp_evk) begin n_fail++; $display("FAIL rnd%0d_evkey got %h want %h", c, evict_key, exp_evk); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_insert();
        test_fill_evict();
        test_reinsert();
        test_inv_insert();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
